// File: rtl/median_filter_ctrl_pkg.sv
// Shared types and constants for the median filter frame-synchronous control logic.
package median_filter_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StHold  = 2'd1,
    StApply = 2'd2
  } mf_state_e;

  localparam int unsigned MfCntWidthDefault = 16;

endpackage

// File: rtl/mf_frame_counter.sv
// Pixel/line counter pair for one AXI4-Stream video side; emits a pulse on the last line's tlast.
module mf_frame_counter
  import median_filter_ctrl_pkg::*;
#(
  parameter int unsigned RES_X     = 1920,
  parameter int unsigned RES_Y     = 1080,
  parameter int unsigned CNT_WIDTH = MfCntWidthDefault,
  parameter bit          COUNT_PX  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic beat_i,
  input  logic eol_i,
  input  logic restart_i,
  output logic idle_o,
  output logic len_err_o,
  output logic done_o
);

  localparam logic [CNT_WIDTH-1:0] PxLast   = CNT_WIDTH'(RES_X - 1);
  localparam logic [CNT_WIDTH-1:0] LineLast = CNT_WIDTH'(RES_Y - 1);

  logic [CNT_WIDTH-1:0] r_px;
  logic [CNT_WIDTH-1:0] r_line;
  logic                 w_line_last;
  logic                 w_eol_beat;

  assign w_line_last = (r_line == LineLast);
  assign w_eol_beat  = beat_i & eol_i & ~restart_i;

  // A restart beat is itself the first pixel of a fresh frame.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_px   <= '0;
      r_line <= '0;
    end else if (beat_i) begin
      if (restart_i) begin
        r_px   <= COUNT_PX ? CNT_WIDTH'(1) : '0;
        r_line <= '0;
      end else if (eol_i) begin
        r_px   <= '0;
        r_line <= w_line_last ? '0 : r_line + CNT_WIDTH'(1);
      end else if (COUNT_PX) begin
        r_px <= r_px + CNT_WIDTH'(1);
      end
    end
  end

  assign idle_o    = (r_px == '0) && (r_line == '0);
  assign len_err_o = COUNT_PX & w_eol_beat & (r_px != PxLast);
  assign done_o    = w_eol_beat & w_line_last;

endmodule

// File: rtl/median_filter_frame_ctrl.sv
// Defers CSR filter-enable updates to a drained frame boundary and tracks frame geometry.
module median_filter_frame_ctrl
  import median_filter_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_RES_X = 1920,
  parameter int unsigned FRAME_RES_Y = 1080,
  parameter int unsigned CNT_WIDTH   = MfCntWidthDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 cfg_en_i,
  input  logic                 cfg_upd_i,
  input  logic                 in_valid_i,
  input  logic                 in_ready_i,
  input  logic                 in_sof_i,
  input  logic                 in_eol_i,
  input  logic                 out_valid_i,
  input  logic                 out_ready_i,
  input  logic                 out_eol_i,
  output logic                 in_allow_o,
  output logic                 mf_en_o,
  output logic                 upd_pending_o,
  output logic                 upd_done_o,
  output logic [CNT_WIDTH-1:0] frame_cnt_o,
  output logic                 err_line_len_o,
  output logic                 err_sof_o
);

  mf_state_e            r_state;
  mf_state_e            w_state_nxt;
  logic                 w_allow_nxt;
  logic                 r_in_allow;
  logic                 r_mf_en;
  logic                 r_pending_en;
  logic                 r_upd_pending;
  logic                 r_upd_done;
  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_frame_cnt;
  logic                 r_err_line_len;
  logic                 r_err_sof;

  logic w_in_beat;
  logic w_out_beat;
  logic w_in_idle;
  logic w_in_len_err;
  logic w_in_done;
  logic w_sof_restart;
  logic w_out_idle;
  logic w_out_len_err;
  logic w_out_done;
  logic w_unused;

  assign w_in_beat     = in_valid_i & in_ready_i & r_in_allow;
  assign w_out_beat    = out_valid_i & out_ready_i;
  assign w_sof_restart = w_in_beat & in_sof_i & ~w_in_idle;

  mf_frame_counter #(
    .RES_X     (FRAME_RES_X),
    .RES_Y     (FRAME_RES_Y),
    .CNT_WIDTH (CNT_WIDTH),
    .COUNT_PX  (1'b1)
  ) u_in_cnt (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .beat_i    (w_in_beat),
    .eol_i     (in_eol_i),
    .restart_i (w_sof_restart),
    .idle_o    (w_in_idle),
    .len_err_o (w_in_len_err),
    .done_o    (w_in_done)
  );

  mf_frame_counter #(
    .RES_X     (FRAME_RES_X),
    .RES_Y     (FRAME_RES_Y),
    .CNT_WIDTH (CNT_WIDTH),
    .COUNT_PX  (1'b0)
  ) u_out_cnt (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .beat_i    (w_out_beat),
    .eol_i     (out_eol_i),
    .restart_i (1'b0),
    .idle_o    (w_out_idle),
    .len_err_o (w_out_len_err),
    .done_o    (w_out_done)
  );

  assign w_unused = w_in_done ^ w_out_idle ^ w_out_len_err;

  always_comb begin
    w_state_nxt = r_state;
    w_allow_nxt = 1'b0;
    unique case (r_state)
      StRun: begin
        w_allow_nxt = 1'b1;
        if (r_upd_pending && w_in_idle) w_state_nxt = StHold;
      end
      StHold: begin
        // Keep the gate open while a frame that slipped in during the turn-around finishes.
        w_allow_nxt = ~w_in_idle;
        if (!r_inflight && w_in_idle) w_state_nxt = StApply;
      end
      StApply: w_state_nxt = StRun;
      default: w_state_nxt = StRun;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state        <= StRun;
      r_in_allow     <= 1'b1;
      r_mf_en        <= 1'b0;
      r_pending_en   <= 1'b0;
      r_upd_pending  <= 1'b0;
      r_upd_done     <= 1'b0;
      r_inflight     <= 1'b0;
      r_frame_cnt    <= '0;
      r_err_line_len <= 1'b0;
      r_err_sof      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_allow <= w_allow_nxt;
      r_upd_done <= (r_state == StApply);
      if (r_state == StApply) r_mf_en <= r_pending_en;
      // A request landing in the apply cycle stays pending for the next boundary.
      if (cfg_upd_i) begin
        r_pending_en  <= cfg_en_i;
        r_upd_pending <= 1'b1;
      end else if (r_state == StApply) begin
        r_upd_pending <= 1'b0;
      end
      if (w_in_beat && in_sof_i) r_inflight <= 1'b1;
      else if (w_out_done)       r_inflight <= 1'b0;
      if (w_out_done)    r_frame_cnt    <= r_frame_cnt + CNT_WIDTH'(1);
      if (w_in_len_err)  r_err_line_len <= 1'b1;
      if (w_sof_restart) r_err_sof      <= 1'b1;
    end
  end

  assign in_allow_o     = r_in_allow;
  assign mf_en_o        = r_mf_en;
  assign upd_pending_o  = r_upd_pending;
  assign upd_done_o     = r_upd_done;
  assign frame_cnt_o    = r_frame_cnt;
  assign err_line_len_o = r_err_line_len;
  assign err_sof_o      = r_err_sof;

endmodule

// File: tb/tb_median_filter_frame_ctrl.sv
// Scenario bench for median_filter_frame_ctrl: 4x2 frames, plus a 2-bit frame counter instance.
module tb_median_filter_frame_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_en = 1'b0, cfg_upd = 1'b0;
  logic in_valid = 1'b0, in_ready = 1'b0, in_sof = 1'b0, in_eol = 1'b0;
  logic out_valid = 1'b0, out_ready = 1'b0, out_eol = 1'b0;

  logic       in_allow, mf_en, upd_pending, upd_done, err_line_len, err_sof;
  logic [2:0] frame_cnt;
  logic       w_in_allow, w_mf_en, w_upd_pending, w_upd_done, w_err_line_len, w_err_sof;
  logic [1:0] w_frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  bit sb_q[$];
  int sb_cnt_q[$];
  int sb_cntw_q[$];

  always #5 clk = ~clk;

  median_filter_frame_ctrl #(
    .FRAME_RES_X (4),
    .FRAME_RES_Y (2),
    .CNT_WIDTH   (3)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .cfg_en_i       (cfg_en),
    .cfg_upd_i      (cfg_upd),
    .in_valid_i     (in_valid),
    .in_ready_i     (in_ready),
    .in_sof_i       (in_sof),
    .in_eol_i       (in_eol),
    .out_valid_i    (out_valid),
    .out_ready_i    (out_ready),
    .out_eol_i      (out_eol),
    .in_allow_o     (in_allow),
    .mf_en_o        (mf_en),
    .upd_pending_o  (upd_pending),
    .upd_done_o     (upd_done),
    .frame_cnt_o    (frame_cnt),
    .err_line_len_o (err_line_len),
    .err_sof_o      (err_sof)
  );

  median_filter_frame_ctrl #(
    .FRAME_RES_X (3),
    .FRAME_RES_Y (2),
    .CNT_WIDTH   (2)
  ) dut_w (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .cfg_en_i       (cfg_en),
    .cfg_upd_i      (cfg_upd),
    .in_valid_i     (in_valid),
    .in_ready_i     (in_ready),
    .in_sof_i       (in_sof),
    .in_eol_i       (in_eol),
    .out_valid_i    (out_valid),
    .out_ready_i    (out_ready),
    .out_eol_i      (out_eol),
    .in_allow_o     (w_in_allow),
    .mf_en_o        (w_mf_en),
    .upd_pending_o  (w_upd_pending),
    .upd_done_o     (w_upd_done),
    .frame_cnt_o    (w_frame_cnt),
    .err_line_len_o (w_err_line_len),
    .err_sof_o      (w_err_sof)
  );

  // Every applied update must carry the enable value the bench queued for it.
  always @(negedge clk) begin
    if (rst_n && upd_done === 1'b1) begin
      n_done++;
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: upd_done=1 at %0t, required no apply", $time);
      end else begin
        bit exp_en;
        exp_en = sb_q.pop_front();
        if (mf_en !== exp_en) begin
          n_fail++;
          $display("FAIL sb_mf_en: mf_en=%b, required %b", mf_en, exp_en);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_en = 1'b0; cfg_upd = 1'b0;
    in_valid = 1'b0; in_ready = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    out_valid = 1'b0; out_ready = 1'b0; out_eol = 1'b0;
    sb_q.delete();
    sb_cnt_q.delete();
    sb_cntw_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic drive_out_frame();
    out_valid = 1'b1;
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      out_eol = (b % 4 == 3);
      step();
    end
    out_valid = 1'b0;
    out_eol = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests += 7;
    if (in_allow !== 1'b1) begin n_fail++; $display("FAIL rst_allow: %b, required 1", in_allow); end
    if (mf_en !== 1'b0) begin n_fail++; $display("FAIL rst_mf_en: %b, required 0", mf_en); end
    if (upd_pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending: %b, required 0", upd_pending); end
    if (upd_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: %b, required 0", upd_done); end
    if (frame_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_frame_cnt: %0d, required 0", frame_cnt); end
    if (err_line_len !== 1'b0) begin n_fail++; $display("FAIL rst_err_len: %b, required 0", err_line_len); end
    if (err_sof !== 1'b0) begin n_fail++; $display("FAIL rst_err_sof: %b, required 0", err_sof); end
  endtask

  task automatic test_idle_update();
    do_reset();
    cfg_en = 1'b1;
    cfg_upd = 1'b1;
    sb_q.push_back(1'b1);
    step();
    cfg_upd = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      n_tests += 4;
      if (in_allow !== !(c == 3 || c == 4)) begin
        n_fail++; $display("FAIL idle_allow c%0d: %b, required %b", c, in_allow, !(c == 3 || c == 4));
      end
      if (upd_done !== (c == 4)) begin
        n_fail++; $display("FAIL idle_done c%0d: %b, required %b", c, upd_done, (c == 4));
      end
      if (mf_en !== (c >= 4)) begin
        n_fail++; $display("FAIL idle_mf_en c%0d: %b, required %b", c, mf_en, (c >= 4));
      end
      if (upd_pending !== (c <= 3)) begin
        n_fail++; $display("FAIL idle_pending c%0d: %b, required %b", c, upd_pending, (c <= 3));
      end
      step();
    end
  endtask

  // Update requested mid-frame; optionally a second, overriding request later in the frame.
  task automatic run_deferred(input bit two_pulses, input string tag);
    int k;
    int done_before;
    do_reset();
    done_before = n_done;
    in_valid = 1'b1;
    in_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      n_tests++;
      if (in_allow !== 1'b1) begin
        n_fail++; $display("FAIL %s_allow_beat%0d: %b, required 1", tag, b, in_allow);
      end
      in_sof = (b == 0);
      in_eol = (b % 4 == 3);
      cfg_upd = 1'b0;
      if (b == 2) begin
        cfg_en = 1'b1; cfg_upd = 1'b1; sb_q.push_back(1'b1);
      end else if (two_pulses && b == 5) begin
        cfg_en = 1'b0; cfg_upd = 1'b1; sb_q[sb_q.size() - 1] = 1'b0;
      end
      step();
    end
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0; cfg_upd = 1'b0;
    k = 0;
    while (in_allow === 1'b1 && k < 8) begin step(); k++; end
    n_tests += 3;
    if (in_allow !== 1'b0) begin n_fail++; $display("FAIL %s_allow_drop: %b, required 0", tag, in_allow); end
    if (mf_en !== 1'b0) begin n_fail++; $display("FAIL %s_mf_en_hold: %b, required 0", tag, mf_en); end
    if (upd_pending !== 1'b1) begin n_fail++; $display("FAIL %s_pend_hold: %b, required 1", tag, upd_pending); end
    out_valid = 1'b1;
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      n_tests++;
      if (in_allow !== 1'b0) begin
        n_fail++; $display("FAIL %s_allow_drain%0d: %b, required 0", tag, b, in_allow);
      end
      out_eol = (b % 4 == 3);
      step();
    end
    out_valid = 1'b0; out_eol = 1'b0;
    k = 0;
    while (in_allow !== 1'b1 && k < 10) begin step(); k++; end
    repeat (4) step();
    n_tests += 5;
    if (in_allow !== 1'b1) begin n_fail++; $display("FAIL %s_allow_return: %b, required 1", tag, in_allow); end
    if (mf_en !== !two_pulses) begin n_fail++; $display("FAIL %s_mf_en: %b, required %b", tag, mf_en, !two_pulses); end
    if (upd_pending !== 1'b0) begin n_fail++; $display("FAIL %s_pend_clr: %b, required 0", tag, upd_pending); end
    if (n_done - done_before !== 1) begin
      n_fail++; $display("FAIL %s_done_count: %0d, required 1", tag, n_done - done_before);
    end
    if (sb_q.size() !== 0) begin n_fail++; $display("FAIL %s_sb_left: %0d, required 0", tag, sb_q.size()); end
  endtask

  task automatic test_frame_boundary();
    run_deferred(1'b0, "boundary");
  endtask

  task automatic test_last_wins();
    run_deferred(1'b1, "lastwins");
  endtask

  task automatic test_errors();
    do_reset();
    in_valid = 1'b1;
    in_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      in_sof = (b == 0); in_eol = (b == 2); step();
    end
    in_sof = 1'b0; in_eol = 1'b0;
    n_tests += 2;
    if (err_line_len !== 1'b1) begin n_fail++; $display("FAIL err_len_set: %b, required 1", err_line_len); end
    if (err_sof !== 1'b0) begin n_fail++; $display("FAIL err_sof_early: %b, required 0", err_sof); end
    step(); step();
    n_tests++;
    if (err_sof !== 1'b0) begin n_fail++; $display("FAIL err_sof_pre: %b, required 0", err_sof); end
    in_sof = 1'b1; step();
    in_sof = 1'b0; in_valid = 1'b0;
    repeat (3) step();
    n_tests += 2;
    if (err_sof !== 1'b1) begin n_fail++; $display("FAIL err_sof_set: %b, required 1", err_sof); end
    if (err_line_len !== 1'b1) begin n_fail++; $display("FAIL err_len_sticky: %b, required 1", err_line_len); end
  endtask

  task automatic test_frame_count();
    int exp_cnt;
    int exp_cntw;
    do_reset();
    out_valid = 1'b1;
    for (int f = 0; f < 4; f++) begin
      sb_cnt_q.push_back((f + 1) % 8);
      sb_cntw_q.push_back((f + 1) % 4);
      for (int ln = 0; ln < 2; ln++) begin
        for (int px = 0; px < 4; px++) begin
          out_eol = (px == 3);
          out_ready = 1'b0;
          step();
          if (px == 3 && ln == 1) begin
            n_tests++;
            if (frame_cnt !== 3'(f)) begin
              n_fail++; $display("FAIL cnt_stall f%0d: %0d, required %0d", f, frame_cnt, f);
            end
          end
          out_ready = 1'b1;
          step();
        end
      end
      exp_cnt = sb_cnt_q.pop_front();
      exp_cntw = sb_cntw_q.pop_front();
      n_tests += 2;
      if (frame_cnt !== 3'(exp_cnt)) begin
        n_fail++; $display("FAIL cnt_frame f%0d: %0d, required %0d", f, frame_cnt, exp_cnt);
      end
      if (w_frame_cnt !== 2'(exp_cntw)) begin
        n_fail++; $display("FAIL cnt_wrap f%0d: %0d, required %0d", f, w_frame_cnt, exp_cntw);
      end
    end
    out_valid = 1'b0; out_ready = 1'b0; out_eol = 1'b0;
  endtask

  task automatic test_reset_in_hold();
    int k;
    do_reset();
    in_valid = 1'b1;
    in_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      in_sof = (b == 0); in_eol = (b % 4 == 3); step();
    end
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    cfg_en = 1'b1; cfg_upd = 1'b1; sb_q.push_back(1'b1);
    step();
    cfg_upd = 1'b0;
    k = 0;
    while (in_allow === 1'b1 && k < 8) begin step(); k++; end
    n_tests += 2;
    if (in_allow !== 1'b0) begin n_fail++; $display("FAIL hold_allow: %b, required 0", in_allow); end
    if (upd_pending !== 1'b1) begin n_fail++; $display("FAIL hold_pending: %b, required 1", upd_pending); end
    #2 rst_n = 1'b0;
    sb_q.delete();
    #1;
    n_tests += 4;
    if (in_allow !== 1'b1) begin n_fail++; $display("FAIL arst_allow: %b, required 1", in_allow); end
    if (upd_pending !== 1'b0) begin n_fail++; $display("FAIL arst_pending: %b, required 0", upd_pending); end
    if (mf_en !== 1'b0) begin n_fail++; $display("FAIL arst_mf_en: %b, required 0", mf_en); end
    if (upd_done !== 1'b0) begin n_fail++; $display("FAIL arst_done: %b, required 0", upd_done); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) step();
    n_tests += 3;
    if (upd_pending !== 1'b0) begin n_fail++; $display("FAIL post_pending: %b, required 0", upd_pending); end
    if (mf_en !== 1'b0) begin n_fail++; $display("FAIL post_mf_en: %b, required 0", mf_en); end
    if (in_allow !== 1'b1) begin n_fail++; $display("FAIL post_allow: %b, required 1", in_allow); end
  endtask

  initial begin
    test_reset();
    test_idle_update();
    test_frame_boundary();
    test_last_wins();
    test_errors();
    test_frame_count();
    test_reset_in_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
